// File: rtl/fp32_pkg.sv
// Shared types and constants for the fp32 multiplier normalise/round back end.
package fp32_pkg;

  localparam int unsigned MANT_PROD_W  = 41;
  localparam int unsigned EXP_IN_W     = 10;
  localparam int unsigned EXP_W        = 11;
  localparam int unsigned FRAC_W       = 23;
  localparam int unsigned LZ_W         = 6;
  localparam int unsigned FP32_EXP_MAX = 255;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  // Special-case class produced by the exponent/mantissa stages
  typedef enum logic [1:0] {
    FP_NORMAL = 2'b00,
    FP_ZERO   = 2'b01,
    FP_INF    = 2'b10,
    FP_NAN    = 2'b11
  } fp_class_e;

  // Normalised product held between the normalise and round stages
  typedef struct packed {
    logic                    sign;
    fp_class_e               cls;
    logic signed [EXP_W-1:0] e;
    logic [FRAC_W-1:0]       frac;
`ifdef FP32_MULT_NORM_RNE_EN
    logic                    guard;
    logic                    sticky;
`endif
  } norm_t;

endpackage

// File: rtl/fp32_lzc41.sv
// Combinational leading-zero counter for the 41-bit mantissa product (41 when all zero).
module fp32_lzc41
  import fp32_pkg::*;
(
  input  logic [MANT_PROD_W-1:0] mant,
  output logic [LZ_W-1:0]        lz_c
);

  // Highest set bit wins; scanning upward lets the last hit overwrite earlier ones
  always_comb begin
    lz_c = LZ_W'(MANT_PROD_W);
    for (int i = 0; i < int'(MANT_PROD_W); i++) begin
      if (mant[i]) lz_c = LZ_W'(int'(MANT_PROD_W) - 1 - i);
    end
  end

endmodule

// File: rtl/fp32_mult_norm.sv
// Normalise-and-round back end of the fp32 multiplier: two-stage valid/ready pipeline.
// Build option: FP32_MULT_NORM_RNE_EN selects round-to-nearest-even; otherwise truncation.
module fp32_mult_norm
  import fp32_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_IN_W-1:0]    in_exp,
  input  logic [MANT_PROD_W-1:0] in_mant,
  input  logic [1:0]             in_class,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_float
);

`ifdef FP32_MULT_NORM_RNE_EN
  localparam int unsigned NORM_W = MANT_PROD_W;
`else
  localparam int unsigned NORM_W = FRAC_W + 1;
`endif
  localparam int unsigned SUM_W = FRAC_W + 1;
  localparam logic signed [EXP_W-1:0] E_INF  = EXP_W'(FP32_EXP_MAX);
  localparam logic signed [EXP_W-1:0] E_ZERO = EXP_W'(0);

  logic                    a_valid;
  logic                    a_load_c;
  logic                    b_load_c;
  norm_t                   a_d_c;
  norm_t                   a_q;
  logic [LZ_W-1:0]         lz_c;
  logic [NORM_W-1:0]       norm_c;
  logic                    inc_c;
  logic [SUM_W-1:0]        frac_sum_c;
  logic signed [EXP_W-1:0] e_rnd_c;
  logic [FRAC_W-1:0]       frac_rnd_c;
  logic [31:0]             pack_c;

  fp32_lzc41 u_lzc (
    .mant (in_mant),
    .lz_c (lz_c)
  );

  // Ready ripples back combinationally so a full pipe still accepts while draining
  assign b_load_c = !out_valid | out_ready;
  assign a_load_c = !a_valid | b_load_c;
  assign in_ready = a_load_c;

  // Stage A: shift the leading one to the top; only the bits rounding needs are kept
  assign norm_c = NORM_W'((in_mant << lz_c) >> (MANT_PROD_W - NORM_W));

  // Stage A next value: exponent adjust, fraction/round bits, zero-mantissa reclass
  always_comb begin
    a_d_c      = '0;
    a_d_c.sign = in_sign;
    a_d_c.cls  = fp_class_e'(in_class);
    if (a_d_c.cls == FP_NORMAL && !norm_c[NORM_W-1]) a_d_c.cls = FP_ZERO;
    a_d_c.e    = {in_exp[EXP_IN_W-1], in_exp} + EXP_W'(1) - EXP_W'(lz_c);
    a_d_c.frac = norm_c[NORM_W-2 -: FRAC_W];
`ifdef FP32_MULT_NORM_RNE_EN
    a_d_c.guard  = norm_c[NORM_W-2-FRAC_W];
    a_d_c.sticky = |norm_c[NORM_W-3-FRAC_W:0];
`endif
  end

  // Stage A register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_valid <= 1'b0;
      a_q     <= '0;
    end else if (a_load_c) begin
      a_valid <= in_valid;
      if (in_valid) a_q <= a_d_c;
    end
  end

  // Stage B: round, handle mantissa carry, range-check exponent and pack by class
  always_comb begin
`ifdef FP32_MULT_NORM_RNE_EN
    inc_c = a_q.guard & (a_q.sticky | a_q.frac[0]);
`else
    inc_c = 1'b0;
`endif
    frac_sum_c = {1'b0, a_q.frac} + SUM_W'(inc_c);
    e_rnd_c    = a_q.e + EXP_W'(frac_sum_c[FRAC_W]);
    frac_rnd_c = frac_sum_c[FRAC_W] ? '0 : frac_sum_c[FRAC_W-1:0];
    pack_c     = {a_q.sign, 31'b0};
    case (a_q.cls)
      FP_NAN:  pack_c = FP32_QNAN;
      FP_INF:  pack_c = {a_q.sign, 8'hFF, 23'b0};
      FP_ZERO: pack_c = {a_q.sign, 31'b0};
      default: begin
        if (e_rnd_c >= E_INF)       pack_c = {a_q.sign, 8'hFF, 23'b0};
        else if (e_rnd_c <= E_ZERO) pack_c = {a_q.sign, 31'b0};
        else                        pack_c = {a_q.sign, e_rnd_c[7:0], frac_rnd_c};
      end
    endcase
  end

  // Stage B register drives the outputs directly; holds while stalled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_float <= 32'h0;
    end else if (b_load_c) begin
      out_valid <= a_valid;
      if (a_valid) out_float <= pack_c;
    end
  end

endmodule

// File: tb/tb_fp32_mult_norm.sv
// Self-checking bench for fp32_mult_norm: directed corner cases plus randomized stream
// scored against an arithmetic reference model. Honours FP32_MULT_NORM_RNE_EN.
module tb_fp32_mult_norm;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exp = '0;
  logic [40:0] in_mant = '0;
  logic [1:0]  in_class = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_float;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] expq[$];
  string       tagq[$];
  logic [31:0] cur_exp;
  string       cur_tag;
  bit          held_v = 1'b0;
  logic [31:0] held_d;
  int          stall_left = 0;
  bit          rnd_ready = 1'b0;
  int          saw_nr = 0;

`ifdef FP32_MULT_NORM_RNE_EN
  localparam logic [31:0] EXP_TIE_ODD = 32'h3F80_0002;
  localparam logic [31:0] EXP_ABOVE   = 32'h3F80_0001;
  localparam logic [31:0] EXP_CARRY   = 32'h4000_0000;
  localparam logic [31:0] EXP_MAXN    = 32'h7F80_0000;
`else
  localparam logic [31:0] EXP_TIE_ODD = 32'h3F80_0001;
  localparam logic [31:0] EXP_ABOVE   = 32'h3F80_0000;
  localparam logic [31:0] EXP_CARRY   = 32'h3FFF_FFFF;
  localparam logic [31:0] EXP_MAXN    = 32'h7F7F_FFFF;
`endif

  fp32_mult_norm dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_class  (in_class),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_float (out_float)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: value = mant/2^39 * 2^(exp-127); round the 24-bit significand exactly
  function automatic logic [31:0] model(input logic s, input logic [9:0] ex,
                                        input logic [40:0] m, input logic [1:0] c);
    longint mv;
    longint sig;
    int     p;
    int     e;
`ifdef FP32_MULT_NORM_RNE_EN
    longint rem;
    longint half;
`endif
    if (c == 2'b11) return 32'h7FC0_0000;
    if (c == 2'b10) return {s, 8'hFF, 23'b0};
    if (c == 2'b01 || m == '0) return {s, 31'b0};
    mv = longint'(m);
    p  = 0;
    for (int i = 0; i < 41; i++) if (m[i]) p = i;
    e = int'($signed(ex)) + p - 39;
    if (p > 23) begin
      sig = mv >> (p - 23);
`ifdef FP32_MULT_NORM_RNE_EN
      rem  = mv - (sig << (p - 23));
      half = longint'(1) << (p - 24);
      if (rem > half || (rem == half && sig[0])) sig = sig + 1;
`endif
    end else begin
      sig = mv << (23 - p);
    end
    if (sig == (longint'(1) << 24)) begin
      sig = sig >> 1;
      e   = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'b0};
    if (e <= 0) return {s, 31'b0};
    return {s, 8'(e), 23'(sig)};
  endfunction

  // One clock: account for handshakes seen at this negedge, then advance to the next negedge
  task automatic step(output bit acc);
    acc = 1'b0;
    if (stall_left > 0) begin
      out_ready  = 1'b0;
      stall_left = stall_left - 1;
    end else begin
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    #1;
    if (held_v) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", out_float, held_d);
    end
    held_v = out_valid && !out_ready;
    held_d = out_float;
    if (out_valid && out_ready) begin
      if (expq.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
      else chk(tagq.pop_front(), out_float, expq.pop_front());
    end
    if (in_valid && !in_ready) saw_nr++;
    if (in_valid && in_ready) begin
      expq.push_back(cur_exp);
      tagq.push_back(cur_tag);
      acc = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input string tag, input logic s, input logic [9:0] ex,
                      input logic [40:0] m, input logic [1:0] c, input logic [31:0] e);
    bit acc;
    int n = 0;
    in_sign  = s;
    in_exp   = ex;
    in_mant  = m;
    in_class = c;
    in_valid = 1'b1;
    cur_exp  = e;
    cur_tag  = tag;
    do begin
      step(acc);
      n++;
    end while (!acc && n < 200);
    if (!acc) chk({"accept_", tag}, 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    in_valid = 1'b0;
    while (expq.size() != 0 && n < 100) begin
      step(acc);
      n++;
    end
    chk("drain_empty", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    bit          acc;
    logic        s;
    logic [9:0]  ex;
    logic [40:0] m;
    logic [1:0]  c;
    int          r;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_float", out_float, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rstn = 1'b1;
    @(negedge clk);

    // Latency from accept to out_valid, 1.5 x 1.5
    in_sign = 1'b0; in_exp = 10'd127; in_mant = 41'h120_0000_0000; in_class = 2'b00;
    in_valid = 1'b1; cur_exp = 32'h4010_0000; cur_tag = "mul_1p5";
    chk("ready_idle", 32'(in_ready), 32'd1);
    step(acc);
    in_valid = 1'b0;
    chk("lat_accept", 32'(acc), 32'd1);
    chk("lat_edge1_valid", 32'(out_valid), 32'd0);
    step(acc);
    chk("lat_edge2_valid", 32'(out_valid), 32'd1);
    chk("lat_edge2_data", out_float, 32'h4010_0000);
    drain();

    // Directed rounding, range and class corners
    send("tie_even",   1'b0, 10'd127, 41'h080_0000_8000, 2'b00, 32'h3F80_0000);
    send("tie_odd",    1'b0, 10'd127, 41'h080_0001_8000, 2'b00, EXP_TIE_ODD);
    send("above_half", 1'b0, 10'd127, 41'h080_0000_8001, 2'b00, EXP_ABOVE);
    send("rnd_carry",  1'b0, 10'd127, 41'h0FF_FFFF_FFFF, 2'b00, EXP_CARRY);
    send("max_normal", 1'b0, 10'd253, 41'h1FF_FFFF_0000, 2'b00, EXP_MAXN);
    send("overflow",   1'b1, 10'd254, 41'h1FF_FFFF_FFFF, 2'b00, 32'hFF80_0000);
    send("underflow",  1'b1, 10'd0,   41'h080_0000_0000, 2'b00, 32'h8000_0000);
    send("neg_exp",    1'b0, 10'h3F0, 41'h100_0000_0000, 2'b00, 32'h0000_0000);
    send("zero_mant",  1'b0, 10'd127, 41'h0,             2'b00, 32'h0000_0000);
    send("cls_nan",    1'b1, 10'd5,   41'h123_4567_89AB, 2'b11, 32'h7FC0_0000);
    send("cls_inf",    1'b0, 10'd5,   41'h0,             2'b10, 32'h7F80_0000);
    send("cls_zero",   1'b1, 10'd200, 41'h100_0000_0000, 2'b01, 32'h8000_0000);
    drain();

    // Backpressure: 4 back-to-back products with the output stalled for 3 cycles
    saw_nr = 0;
    stall_left = 3;
    send("bp0", 1'b0, 10'd127, 41'h120_0000_0000, 2'b00, 32'h4010_0000);
    send("bp1", 1'b1, 10'd254, 41'h1FF_FFFF_FFFF, 2'b00, 32'hFF80_0000);
    send("bp2", 1'b0, 10'd127, 41'h080_0000_8000, 2'b00, 32'h3F80_0000);
    send("bp3", 1'b1, 10'd1,   41'h0,             2'b11, 32'h7FC0_0000);
    drain();
    chk("bp_in_ready_drop", 32'(saw_nr > 0), 32'd1);

    // Reset in the middle of a stalled stream discards everything in flight
    stall_left = 20;
    send("rs0", 1'b0, 10'd130, 41'h150_0000_0000, 2'b00, 32'h0);
    send("rs1", 1'b0, 10'd131, 41'h150_0000_0000, 2'b00, 32'h0);
    rstn = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    expq.delete();
    tagq.delete();
    held_v = 1'b0;
    stall_left = 0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) begin
      step(acc);
      chk("post_rst_idle", 32'(out_valid), 32'd0);
    end
    send("after_rst", 1'b1, 10'd127, 41'h120_0000_0000, 2'b00, 32'hC010_0000);
    drain();

    // Randomized stream with random output stalls and input gaps
    rnd_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      s  = 1'($urandom);
      ex = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(40, 230)) : 10'($urandom);
      m  = 41'({$urandom, $urandom}) >> $urandom_range(0, 41);
      r  = int'($urandom_range(0, 9));
      c  = (r < 7) ? 2'b00 : (r == 7) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
      send("rand", s, ex, m, c, model(s, ex, m, c));
      if ($urandom_range(0, 3) == 0) step(acc);
    end
    rnd_ready = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
